// File: rtl/ex_muldiv_pkg.sv
// Shared opcodes, widths and state encoding for the execute-stage multiply / HI-LO unit.
package ex_muldiv_pkg;

  localparam int unsigned REG_W    = 32;
  localparam int unsigned ALUOP_W  = 8;
  localparam int unsigned DREG_W   = 2 * REG_W;

  localparam logic [ALUOP_W-1:0] EXE_MFHI_OP  = 8'b00010000;
  localparam logic [ALUOP_W-1:0] EXE_MTHI_OP  = 8'b00010001;
  localparam logic [ALUOP_W-1:0] EXE_MFLO_OP  = 8'b00010010;
  localparam logic [ALUOP_W-1:0] EXE_MTLO_OP  = 8'b00010011;
  localparam logic [ALUOP_W-1:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [ALUOP_W-1:0] EXE_MULTU_OP = 8'b00011001;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_e;

endpackage

// File: rtl/ex_muldiv_iter_core.sv
// Iterative shift-add multiplier datapath: accumulator, shift registers, step counter.
// Optional MULDIV_EARLY_TERM_EN: flag the last step as soon as the remaining multiplier is zero.
module mul_iter_core #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  step,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic [2*DATA_W-1:0]   acc,
  output logic                  last
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  logic [2*DATA_W-1:0] mcand_q;
  logic [2*DATA_W-1:0] acc_q;
  logic [DATA_W-1:0]   mplier_q;
  logic [CNT_W-1:0]    cnt_q;

  // Multiplicand is shifted one place per step, equivalent to adding mcand << counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      mcand_q  <= {{DATA_W{1'b0}}, a};
      acc_q    <= '0;
      mplier_q <= b;
      cnt_q    <= '0;
    end else if (step) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    last = (cnt_q == CNT_W'(DATA_W - 1));
`ifdef MULDIV_EARLY_TERM_EN
    if (mplier_q[DATA_W-1:1] == '0) begin
      last = 1'b1;
    end
`endif
  end

  assign acc = acc_q;

endmodule

// File: rtl/ex_muldiv.sv
// Execute-stage multiply and HI/LO unit: FSM, HI/LO registers, MTHI/MTLO writes, MFHI/MFLO mux.
// Optional MULDIV_EARLY_TERM_EN shortens BUSY when the multiplier runs out of set bits.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   aluop_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              stallreq_o,
  output logic [DATA_W-1:0] result_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              busy_o
);

  mul_state_e state_q, state_d;

  logic [DATA_W-1:0]   hi_q, lo_q;
  logic                sign_q;
  logic                is_mult, is_signed, is_mthi, is_mtlo;
  logic                start, step, last, done_wr, mt_ok;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [2*DATA_W-1:0] acc, product;

  assign is_signed = (aluop_i == OP_W'(EXE_MULT_OP));
  assign is_mult   = is_signed || (aluop_i == OP_W'(EXE_MULTU_OP));
  assign is_mthi   = (aluop_i == OP_W'(EXE_MTHI_OP));
  assign is_mtlo   = (aluop_i == OP_W'(EXE_MTLO_OP));

  assign a_mag = (is_signed && reg1_i[DATA_W-1]) ? -reg1_i : reg1_i;
  assign b_mag = (is_signed && reg2_i[DATA_W-1]) ? -reg2_i : reg2_i;

  mul_iter_core #(.DATA_W(DATA_W)) u_core (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .step  (step),
    .a     (a_mag),
    .b     (b_mag),
    .acc   (acc),
    .last  (last)
  );

  assign product = sign_q ? -acc : acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MUL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    step    = 1'b0;
    done_wr = 1'b0;
    mt_ok   = 1'b0;
    case (state_q)
      MUL_IDLE: begin
        mt_ok = !stall_i && !flush_i;
        if (is_mult && !flush_i) begin
          start   = 1'b1;
          state_d = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        step = !flush_i;
        if (flush_i) begin
          state_d = MUL_IDLE;
        end else if (last) begin
          state_d = MUL_DONE;
        end
      end
      MUL_DONE: begin
        if (flush_i) begin
          state_d = MUL_IDLE;
        end else if (!stall_i) begin
          done_wr = 1'b1;
          state_d = MUL_IDLE;
        end
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign_q <= 1'b0;
    end else if (start) begin
      sign_q <= is_signed && (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (done_wr) begin
      hi_q <= product[2*DATA_W-1:DATA_W];
      lo_q <= product[DATA_W-1:0];
    end else if (mt_ok && is_mthi) begin
      hi_q <= reg1_i;
    end else if (mt_ok && is_mtlo) begin
      lo_q <= reg1_i;
    end
  end

  always_comb begin
    result_o = '0;
    if (aluop_i == OP_W'(EXE_MFHI_OP)) begin
      result_o = hi_q;
    end else if (aluop_i == OP_W'(EXE_MFLO_OP)) begin
      result_o = lo_q;
    end
  end

  assign stallreq_o = !flush_i && (((state_q == MUL_IDLE) && is_mult) || (state_q == MUL_BUSY));
  assign busy_o     = (state_q != MUL_IDLE);
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv (works with or without MULDIV_EARLY_TERM_EN).
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

`ifdef MULDIV_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
  localparam int FLUSH_AT = 2;
`else
  localparam bit EARLY = 1'b0;
  localparam int FLUSH_AT = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  aluop = '0;
  logic [31:0] reg1 = '0;
  logic [31:0] reg2 = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        stallreq, busy;
  logic [31:0] result, hi, lo;

  int total = 0;
  int bad = 0;

  ex_muldiv #(.DATA_W(32), .OP_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop),
    .reg1_i     (reg1),
    .reg2_i     (reg2),
    .stall_i    (stall),
    .flush_i    (flush),
    .stallreq_o (stallreq),
    .result_o   (result),
    .hi_o       (hi),
    .lo_o       (lo),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Stall cycles = issue cycle + BUSY cycles.
  function automatic int exp_stall(input logic [31:0] bmag);
    int n = 1;
    for (int i = 0; i < 32; i++) if (bmag[i]) n = i + 1;
    return EARLY ? n + 1 : 33;
  endfunction

  task automatic run_mul(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] bmag,
                         input logic [63:0] exp);
    int cnt = 0;
    aluop = op; reg1 = a; reg2 = b;
    #1;
    while (stallreq && cnt < 100) begin
      cnt++;
      @(negedge clk);
      aluop = '0;
      #1;
    end
    check({tag, "_stall"}, 64'(cnt), 64'(exp_stall(bmag)));
    check({tag, "_done"}, {63'd0, busy}, 64'd1);
    @(negedge clk);
    #1;
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, exp[63:32]});
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, exp[31:0]});
    check({tag, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int cnt;
    #12;
    check("rst_stallreq", {63'd0, stallreq}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // flush during BUSY
    @(negedge clk);
    aluop = EXE_MULT_OP; reg1 = 32'd7; reg2 = 32'd9;
    #1;
    check("fl_issue_stallreq", {63'd0, stallreq}, 64'd1);
    repeat (FLUSH_AT - 1) begin
      @(negedge clk);
      aluop = '0;
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("fl_busy_before", {63'd0, busy}, 64'd1);
    check("fl_stallreq_forced", {63'd0, stallreq}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("fl_busy_after", {63'd0, busy}, 64'd0);
    check("fl_stallreq_after", {63'd0, stallreq}, 64'd0);
    check("fl_hi", {32'd0, hi}, 64'd0);
    check("fl_lo", {32'd0, lo}, 64'd0);

    @(negedge clk);
    run_mul("mult_m2x3", EXE_MULT_OP, 32'hFFFFFFFE, 32'h3, 32'h3, 64'hFFFFFFFF_FFFFFFFA);
    run_mul("multu_max", EXE_MULTU_OP, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
            64'hFFFFFFFE_00000001);
    run_mul("mult_pmax_m1", EXE_MULT_OP, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h1,
            64'hFFFFFFFF_80000001);
    run_mul("mult_m7xm6", EXE_MULT_OP, 32'hFFFFFFF9, 32'hFFFFFFFA, 32'h6, 64'd42);
    run_mul("multu_5x3", EXE_MULTU_OP, 32'd5, 32'd3, 32'd3, 64'd15);
    run_mul("mult_zero", EXE_MULT_OP, 32'h1234, 32'h0, 32'h0, 64'd0);
    run_mul("mult_min", EXE_MULT_OP, 32'h80000000, 32'h80000000, 32'h80000000,
            64'h40000000_00000000);

    // MTHI then MFHI/MFLO
    aluop = EXE_MTHI_OP; reg1 = 32'h12345678;
    @(negedge clk);
    aluop = EXE_MFHI_OP; reg1 = '0;
    #1;
    check("mfhi_result", {32'd0, result}, 64'h12345678);
    check("mthi_lo_kept", {32'd0, lo}, 64'd0);
    aluop = EXE_MFLO_OP;
    #1;
    check("mflo_result", {32'd0, result}, 64'd0);

    // MTLO held by stall
    aluop = EXE_MTLO_OP; reg1 = 32'hCAFEF00D; stall = 1'b1;
    @(negedge clk);
    #1;
    check("mtlo_stall1", {32'd0, lo}, 64'd0);
    @(negedge clk);
    #1;
    check("mtlo_stall2", {32'd0, lo}, 64'd0);
    stall = 1'b0;
    @(negedge clk);
    aluop = EXE_MFLO_OP; reg1 = '0;
    #1;
    check("mtlo_written", {32'd0, lo}, 64'hCAFEF00D);
    check("mflo_new", {32'd0, result}, 64'hCAFEF00D);
    check("mtlo_hi_kept", {32'd0, hi}, 64'h12345678);
    aluop = '0;
    #1;
    check("nop_result", {32'd0, result}, 64'd0);

    // stall held in DONE; aluop stays MULT until the instruction leaves EX
    @(negedge clk);
    aluop = EXE_MULT_OP; reg1 = 32'd2; reg2 = 32'd3;
    cnt = 0;
    #1;
    while (stallreq && cnt < 100) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    check("dst_stall", 64'(cnt), 64'(exp_stall(32'd3)));
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("dst_lo_held", {32'd0, lo}, 64'hCAFEF00D);
      check("dst_busy_held", {63'd0, busy}, 64'd1);
    end
    stall = 1'b0;
    @(negedge clk);
    aluop = '0;
    #1;
    check("dst_hi", {32'd0, hi}, 64'd0);
    check("dst_lo", {32'd0, lo}, 64'd6);
    check("dst_busy_clear", {63'd0, busy}, 64'd0);
    @(negedge clk);
    #1;
    check("dst_no_restart", {63'd0, busy}, 64'd0);
    check("dst_stallreq", {63'd0, stallreq}, 64'd0);

    // async reset during BUSY
    aluop = EXE_MULT_OP; reg1 = 32'd5; reg2 = 32'd7;
    @(negedge clk);
    aluop = '0;
    #1;
    check("rb_busy", {63'd0, busy}, 64'd1);
    #1;
    rst = 1'b0;
    #1;
    check("rb_busy_clr", {63'd0, busy}, 64'd0);
    check("rb_hi", {32'd0, hi}, 64'd0);
    check("rb_lo", {32'd0, lo}, 64'd0);
    check("rb_stallreq", {63'd0, stallreq}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
